fast_corner_engine: RTL and testbench
=====================================

# fast_corner_engine

Parametrised FAST-N corner scoring engine for the ISP feature path. Once started, it raster-scans a runtime-sized image held in the smoothed-image SRAM. For each pixel it fetches the centre and the 16-pixel Bresenham ring over a 1-cycle-latency read port, and runs a circular segment test with configurable arc length and runtime threshold. It writes one saturated score per pixel to the score SRAM through a ready/valid write port; border pixels score 0.

## Interface
- X_MAX, 640, maximum image width; x fields are $clog2(X_MAX) bits
- Y_MAX, 480, maximum image height; y fields are $clog2(Y_MAX) bits
- PIX_W, 8, pixel width
- ARC_LEN, 9, contiguous ring pixels required for a corner (1..16)
- SCORE_W, 12, score width; saturates at 2^SCORE_W-1
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; ignored unless IDLE
- max_x, max_y  in  x/y width  last column/row index; sampled on start
- threshold  in  PIX_W  sampled on start
- busy  out  1  high from the cycle after start until DONE
- done  out  1  one-cycle pulse at end of frame
- rd_en  out  1  read strobe
- rd_x, rd_y  out  x/y width  read address
- rd_data  in  PIX_W  valid the cycle after rd_en
- wr_en  out  1  score valid
- wr_ready  in  1  score SRAM accepts
- wr_x, wr_y  out  x/y width  score address
- wr_score  out  SCORE_W  score
- corner_count  out  16  corners this frame (see Configuration)

## Operation
- States: IDLE, CHECK, FETCH, DRAIN, EVAL, WRITE, DONE.
- IDLE + start: latch max_x, max_y, threshold. Set (x,y)=(0,0). Go to CHECK.
- CHECK: a pixel is border if x<3, y<3, x>max_x-3, or y>max_y-3; compute in signed arithmetic so that max<3 marks every pixel border. Border pixels go to WRITE with score 0. Interior pixels go to FETCH with idx=0.
- FETCH: 17 cycles. rd_en=1 with address idx0 = centre, then ring idx1..16 at offsets (0,-3),(1,-3),(2,-2),(3,-1),(3,0),(3,1),(2,2),(1,3),(0,3),(-1,3),(-2,2),(-3,1),(-3,0),(-3,-1),(-2,-2),(-1,-3). rd_data is captured one cycle later into reg[idx-1].
- DRAIN: 1 cycle; capture the last ring pixel; rd_en=0.
- EVAL: with c = centre and t = threshold, in PIX_W+2-bit signed arithmetic (no wrap):
  - bright(i) = p_i > c+t; dark(i) = p_i < c-t.
  - Corner = ARC_LEN circularly contiguous bright, or ARC_LEN circularly contiguous dark; ring index 16 wraps to 1.
  - Sb = Σ bright (p_i-c-t); Sd = Σ dark (c-p_i-t).
  - Score = corner ? sat(max(Sb,Sd)) : 0, registered.
- WRITE: wr_en=1, with wr_x/wr_y/wr_score stable until wr_en&&wr_ready. On acceptance, advance x; at max_x wrap x to 0 and y+1. After (max_x,max_y) go to DONE, otherwise go to CHECK.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- start while busy: ignored, no effect on latched configuration.
- Reset at any point: all registers cleared, state IDLE; the partial frame is abandoned.

## Timing
- Reset values: busy, done, rd_en, wr_en = 0; rd_x, rd_y, wr_x, wr_y, wr_score, corner_count = 0.
- Interior pixel with wr_ready=1: CHECK 1 + FETCH 17 + DRAIN 1 + EVAL 1 + WRITE 1 = 21 cycles.
- Border pixel: CHECK 1 + WRITE 1 = 2 cycles.
- Each cycle of wr_ready=0 adds one cycle; no reads are issued while stalled.
- First rd_en (interior) or first wr_en (border, always pixel (0,0)) appears 2 cycles after start.
- done asserts the cycle after the last write is accepted.
- rd_en is never asserted at the same time as wr_en.

## Configuration
- FAST_CORNER_COUNT_EN defined: corner_count is cleared on start and incremented on each accepted write with nonzero score, saturating at 0xFFFF; it holds its value after done.
- Undefined: the counter logic is not built and corner_count is tied to 0.

## Test plan
- 7x7 image, all pixels 100, threshold=20, start → 49 writes in raster order, all score 0. Only (3,3) issues reads (17). done 117 cycles after the CHECK following start.
- 7x7, centre 100, ring idx1..9 =150, others 100, t=20 → write at (3,3) score 270; corner_count=1 with FAST_CORNER_COUNT_EN, 0 without.
- Same image with only idx1..8 =150 → score 0. With idx13..16 and idx1..5 =50 (dark, wrapping arc) → score 270.
- All ring pixels 255, centre 0, t=0, SCORE_W=11 → score saturates to 2047.
- wr_ready held low 5 cycles during the (3,3) write → wr_en and data stable for 6 cycles, rd_en stays 0, total frame time +5.
- n_rst asserted mid-FETCH → all outputs 0 the same cycle. After release, start on a 6x6 frame → 36 zero-score writes, then done.

Source files
------------

// File: rtl/fast_corner_engine_if.sv
// fast_corner_engine_if
//   Memory-side bus of the FAST corner engine: a 1-cycle-latency read port
//   into the smoothed-image SRAM and a ready/valid write port into the
//   score SRAM.
//
//   Handshake rules:
//     read : rd_en/rd_x/rd_y are presented in cycle N. rd_data must hold the
//            addressed pixel during cycle N+1. There is no back-pressure.
//     write: wr_en is valid and wr_ready is ready. A score transfers on a
//            rising edge where wr_en && wr_ready. Once wr_en is raised,
//            wr_x/wr_y/wr_score stay stable until that transfer. wr_ready
//            may toggle freely and never gates wr_en.
//
//   Parameters: XW/YW address widths, PIX_W pixel width, SCORE_W score width.
//   Modports  : master = engine side, slave = SRAM side.

interface fast_corner_engine_if #(
  parameter int XW      = 10,
  parameter int YW      = 9,
  parameter int PIX_W   = 8,
  parameter int SCORE_W = 12
) ();
  logic               rd_en;
  logic [XW-1:0]      rd_x;
  logic [YW-1:0]      rd_y;
  logic [PIX_W-1:0]   rd_data;
  logic               wr_en;
  logic               wr_ready;
  logic [XW-1:0]      wr_x;
  logic [YW-1:0]      wr_y;
  logic [SCORE_W-1:0] wr_score;

  modport master (
    output rd_en, rd_x, rd_y,
    input  rd_data,
    output wr_en, wr_x, wr_y, wr_score,
    input  wr_ready
  );

  modport slave (
    input  rd_en, rd_x, rd_y,
    output rd_data,
    input  wr_en, wr_x, wr_y, wr_score,
    output wr_ready
  );
endinterface

// File: rtl/fast_corner_engine.sv
// fast_corner_engine
//   FAST-N corner scoring engine. After a start pulse it raster-scans a
//   (max_x+1) x (max_y+1) image. For each interior pixel it reads the centre
//   plus the 16-pixel Bresenham ring, runs a circular segment test of
//   ARC_LEN contiguous pixels and writes one saturated score per pixel.
//   Border pixels (within 3 of an edge) are written with score 0.
//
//   Optional feature: define FAST_CORNER_COUNT_EN to build the corner
//   counter. Without it, corner_count is tied to 0.
//
//   Ports:
//     clk, n_rst              clock, asynchronous active-low reset
//     start                   one-cycle pulse, accepted only in IDLE
//     max_x, max_y, threshold frame configuration, latched on start
//     busy                    high from the cycle after start until DONE
//     done                    one-cycle pulse at end of frame
//     corner_count            nonzero-score writes this frame (optional)
//     state_dbg               current FSM state, for debug and assertions
//     bus                     read/write SRAM bus (fast_corner_engine_if.master)

module fast_corner_engine #(
  parameter int X_MAX   = 640,
  parameter int Y_MAX   = 480,
  parameter int PIX_W   = 8,
  parameter int ARC_LEN = 9,
  parameter int SCORE_W = 12,
  localparam int XW = $clog2(X_MAX),
  localparam int YW = $clog2(Y_MAX)
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [XW-1:0]       max_x,
  input  logic [YW-1:0]       max_y,
  input  logic [PIX_W-1:0]    threshold,
  output logic                busy,
  output logic                done,
  output logic [15:0]         corner_count,
  output logic [2:0]          state_dbg,
  fast_corner_engine_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_FETCH, S_DRAIN, S_EVAL, S_WRITE, S_DONE
  } state_t;

  // One extra bit covers c+t, and one more is the sign bit.
  localparam int DW    = PIX_W + 2;
  localparam int ACC_A = PIX_W + 6;
  localparam int ACC_W = (ACC_A > SCORE_W + 1) ? ACC_A : SCORE_W + 1;
  localparam logic [ACC_W-1:0] MAX_SCORE =
    {{(ACC_W-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

  state_t               state, state_nx;
  logic [XW-1:0]        x, cfg_max_x;
  logic [YW-1:0]        y, cfg_max_y;
  logic [PIX_W-1:0]     cfg_thr;
  logic [4:0]           idx;
  logic [PIX_W-1:0]     pix [0:16];   // [0] centre, [1..16] ring
  logic [SCORE_W-1:0]   score;
  logic                 is_border, last_pix, accept;

  // Ring offsets (dx, dy) for fetch index 0 (centre) .. 16.
  function automatic logic signed [2:0] ring_dx(input logic [4:0] i);
    case (i)
      5'd2, 5'd8:                ring_dx = 3'sd1;
      5'd3, 5'd7:                ring_dx = 3'sd2;
      5'd4, 5'd5, 5'd6:          ring_dx = 3'sd3;
      5'd10, 5'd16:              ring_dx = -3'sd1;
      5'd11, 5'd15:              ring_dx = -3'sd2;
      5'd12, 5'd13, 5'd14:       ring_dx = -3'sd3;
      default:                   ring_dx = 3'sd0;
    endcase
  endfunction

  function automatic logic signed [2:0] ring_dy(input logic [4:0] i);
    case (i)
      5'd6, 5'd12:               ring_dy = 3'sd1;
      5'd7, 5'd11:               ring_dy = 3'sd2;
      5'd8, 5'd9, 5'd10:         ring_dy = 3'sd3;
      5'd4, 5'd14:               ring_dy = -3'sd1;
      5'd3, 5'd15:               ring_dy = -3'sd2;
      5'd1, 5'd2, 5'd16:         ring_dy = -3'sd3;
      default:                   ring_dy = 3'sd0;
    endcase
  endfunction

  // Border test in signed arithmetic, so that max < 3 makes every pixel border.
  logic signed [XW+1:0] x_lim;
  logic signed [YW+1:0] y_lim;
  assign x_lim = $signed({2'b00, cfg_max_x}) - $signed((XW+2)'(3));
  assign y_lim = $signed({2'b00, cfg_max_y}) - $signed((YW+2)'(3));
  assign is_border = (x < XW'(3)) || (y < YW'(3)) ||
                     ($signed({2'b00, x}) > x_lim) ||
                     ($signed({2'b00, y}) > y_lim);

  assign last_pix = (x == cfg_max_x) && (y == cfg_max_y);
  assign accept   = (state == S_WRITE) && bus.wr_ready;

  // ---------------- segment test and score ----------------
  logic signed [DW-1:0] c_s, t_s, hi, lo, p_s;
  logic [ACC_W-1:0]     sum_b, sum_d, best;
  logic [15:0]          bright, dark;
  logic                 corner, run_b, run_d;
  logic [SCORE_W-1:0]   eval_score;

  always_comb begin
    c_s    = $signed({2'b00, pix[0]});
    t_s    = $signed({2'b00, cfg_thr});
    hi     = c_s + t_s;
    lo     = c_s - t_s;
    p_s    = '0;
    sum_b  = '0;
    sum_d  = '0;
    bright = '0;
    dark   = '0;
    for (int i = 0; i < 16; i++) begin
      p_s = $signed({2'b00, pix[i+1]});
      if (p_s > hi) begin
        bright[i] = 1'b1;
        sum_b     = sum_b + ACC_W'($unsigned(p_s - hi));
      end
      if (p_s < lo) begin
        dark[i] = 1'b1;
        sum_d   = sum_d + ACC_W'($unsigned(lo - p_s));
      end
    end
    // Try every starting ring position; the arc wraps from index 16 to 1.
    corner = 1'b0;
    run_b  = 1'b0;
    run_d  = 1'b0;
    for (int s = 0; s < 16; s++) begin
      run_b = 1'b1;
      run_d = 1'b1;
      for (int k = 0; k < ARC_LEN; k++) begin
        run_b = run_b & bright[4'((s + k) % 16)];
        run_d = run_d & dark[4'((s + k) % 16)];
      end
      if (run_b || run_d) corner = 1'b1;
    end
    best = (sum_b > sum_d) ? sum_b : sum_d;
    if (!corner)               eval_score = '0;
    else if (best > MAX_SCORE) eval_score = '1;
    else                       eval_score = best[SCORE_W-1:0];
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_nx;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_CHECK;
      S_CHECK: state_nx = is_border ? S_WRITE : S_FETCH;
      S_FETCH: if (idx == 5'd16) state_nx = S_DRAIN;
      S_DRAIN: state_nx = S_EVAL;
      S_EVAL:  state_nx = S_WRITE;
      S_WRITE: if (bus.wr_ready) state_nx = last_pix ? S_DONE : S_CHECK;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  logic signed [2:0] dx, dy;
  assign dx = ring_dx(idx);
  assign dy = ring_dy(idx);

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    bus.rd_en = 1'b0;
    bus.rd_x  = '0;
    bus.rd_y  = '0;
    bus.wr_en = 1'b0;
    case (state)
      S_CHECK, S_DRAIN, S_EVAL: busy = 1'b1;
      S_FETCH: begin
        busy      = 1'b1;
        bus.rd_en = 1'b1;
        bus.rd_x  = x + {{(XW-3){dx[2]}}, dx};
        bus.rd_y  = y + {{(YW-3){dy[2]}}, dy};
      end
      S_WRITE: begin
        busy      = 1'b1;
        bus.wr_en = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign bus.wr_x     = x;
  assign bus.wr_y     = y;
  assign bus.wr_score = score;
  assign state_dbg    = state;

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      x         <= '0;
      y         <= '0;
      cfg_max_x <= '0;
      cfg_max_y <= '0;
      cfg_thr   <= '0;
      idx       <= '0;
      score     <= '0;
      for (int i = 0; i < 17; i++) pix[i] <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        cfg_max_x <= max_x;
        cfg_max_y <= max_y;
        cfg_thr   <= threshold;
        x         <= '0;
        y         <= '0;
      end
      if (state == S_CHECK) begin
        idx <= '0;
        if (is_border) score <= '0;
      end
      if (state == S_FETCH) idx <= idx + 5'd1;
      // Data for the read issued at idx-1 arrives now; DRAIN sees idx=17.
      if ((state == S_FETCH && idx != 5'd0) || state == S_DRAIN)
        pix[idx - 5'd1] <= bus.rd_data;
      if (state == S_EVAL) score <= eval_score;
      if (accept) begin
        if (x == cfg_max_x) begin
          x <= '0;
          y <= y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end
    end
  end

`ifdef FAST_CORNER_COUNT_EN
  logic [15:0] cnt;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                                         cnt <= '0;
    else if (state == S_IDLE && start)                  cnt <= '0;
    else if (accept && score != '0 && cnt != 16'hFFFF)  cnt <= cnt + 16'd1;
  end
  assign corner_count = cnt;
`else
  assign corner_count = '0;
`endif

endmodule

// File: tb/tb_fast_corner_engine.sv
module tb_fast_corner_engine;
  localparam int XW  = 10;
  localparam int YW  = 9;
  localparam int PW  = 8;
  localparam int SW  = 11;
  localparam int ARC = 9;
  localparam int W   = XW + YW + SW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic           start = 1'b0;
  logic [XW-1:0]  max_x = '0;
  logic [YW-1:0]  max_y = '0;
  logic [PW-1:0]  threshold = '0;
  logic           busy, done;
  logic [15:0]    corner_count;
  logic [2:0]     state_dbg;

  fast_corner_engine_if #(.XW(XW), .YW(YW), .PIX_W(PW), .SCORE_W(SW)) bus ();

  fast_corner_engine #(
    .X_MAX(640), .Y_MAX(480), .PIX_W(PW), .ARC_LEN(ARC), .SCORE_W(SW)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .max_x(max_x), .max_y(max_y),
    .threshold(threshold), .busy(busy), .done(done),
    .corner_count(corner_count), .state_dbg(state_dbg), .bus(bus)
  );

  // ---------------- image memory model ----------------
  logic [7:0] mem [0:15][0:15];
  int rdx [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  int rdy [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

  always @(posedge clk) begin
    if (bus.rd_en) begin
      if (int'(bus.rd_x) < 16 && int'(bus.rd_y) < 16)
        bus.rd_data <= mem[int'(bus.rd_y)][int'(bus.rd_x)];
      else
        bus.rd_data <= 8'd0;
    end
  end

  // wr_ready policy: 0 always ready, 1 random, 2 stall pixel (3,3) for 5 cycles
  int ready_mode = 0;
  int stall_cnt  = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: bus.wr_ready = ($urandom_range(0, 3) != 0);
      2: if (bus.wr_en && int'(bus.wr_x) == 3 && int'(bus.wr_y) == 3 && stall_cnt < 5) begin
           bus.wr_ready = 1'b0;
           stall_cnt++;
         end else bus.wr_ready = 1'b1;
      default: bus.wr_ready = 1'b1;
    endcase
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  logic         hold_pend = 1'b0;
  logic [W-1:0] hold_val;
  always @(negedge clk) begin
    logic [W-1:0] got, exp;
    if (!n_rst) hold_pend = 1'b0;
    else begin
      got = {bus.wr_x, bus.wr_y, bus.wr_score};
      if (bus.rd_en) rd_cnt++;
      if (bus.rd_en || bus.wr_en) begin
        checks++;
        if (bus.rd_en && bus.wr_en) begin
          errors++;
          $display("FAIL rd_wr_overlap rd_en=1 wr_en=1 required not both");
        end
      end
      if (hold_pend) begin
        checks++;
        if (!bus.wr_en || got !== hold_val) begin
          errors++;
          $display("FAIL wr_hold got wr_en=%0d data=%h required wr_en=1 data=%h",
                   bus.wr_en, got, hold_val);
        end
      end
      if (bus.wr_en && bus.wr_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write x=%0d y=%0d score=%0d", bus.wr_x, bus.wr_y, bus.wr_score);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL write got x=%0d y=%0d score=%0d required x=%0d y=%0d score=%0d",
                     bus.wr_x, bus.wr_y, bus.wr_score,
                     exp[W-1 -: XW], exp[SW+YW-1 -: YW], exp[SW-1:0]);
          end
        end
      end
      hold_pend = bus.wr_en && !bus.wr_ready;
      hold_val  = got;
    end
  end

  // ---------------- reference model ----------------
  function automatic bit ref_border(int x, int y, int mx, int my);
    return (x < 3) || (y < 3) || (x > mx - 3) || (y > my - 3);
  endfunction

  function automatic int ref_score(int x, int y, int mx, int my, int t);
    int c, p, sb, sd, best, run;
    bit br [16];
    bit dk [16];
    bit corner;
    if (ref_border(x, y, mx, my)) return 0;
    c = mem[y][x];
    sb = 0; sd = 0; corner = 0;
    for (int i = 0; i < 16; i++) begin
      p = mem[y + rdy[i]][x + rdx[i]];
      br[i] = p > c + t;
      dk[i] = p < c - t;
      if (br[i]) sb += p - c - t;
      if (dk[i]) sd += c - p - t;
    end
    for (int s = 0; s < 16; s++) begin
      run = 0;
      while (run < 16 && br[(s + run) % 16]) run++;
      if (run >= ARC) corner = 1;
      run = 0;
      while (run < 16 && dk[(s + run) % 16]) run++;
      if (run >= ARC) corner = 1;
    end
    if (!corner) return 0;
    best = (sb > sd) ? sb : sd;
    return (best > (1 << SW) - 1) ? (1 << SW) - 1 : best;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic fill(input int v);
    for (int yy = 0; yy < 16; yy++)
      for (int xx = 0; xx < 16; xx++) mem[yy][xx] = 8'(v);
  endtask

  task automatic set_ring(input int lo_i, input int hi_i, input int v);
    // ring indices lo_i..hi_i (1-based) around the centre (3,3)
    for (int i = lo_i; i <= hi_i; i++) mem[3 + rdy[i-1]][3 + rdx[i-1]] = 8'(v);
  endtask

  task automatic random_image();
    int cx, cy, len, s, v;
    for (int yy = 0; yy < 16; yy++)
      for (int xx = 0; xx < 16; xx++) mem[yy][xx] = 8'($urandom_range(80, 120));
    repeat (8) begin
      cx = $urandom_range(3, 12); cy = $urandom_range(3, 12);
      len = $urandom_range(6, 13); s = $urandom_range(0, 15);
      v = $urandom_range(0, 1) ? 230 : 10;
      for (int k = 0; k < len; k++)
        mem[cy + rdy[(s + k) % 16]][cx + rdx[(s + k) % 16]] = 8'(v);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, bus.rd_en, 0);
    chk({tag, "_wr_en"}, bus.wr_en, 0);
    chk({tag, "_rd_addr"}, {bus.rd_x, bus.rd_y}, 0);
    chk({tag, "_wr_addr"}, {bus.wr_x, bus.wr_y}, 0);
    chk({tag, "_wr_score"}, bus.wr_score, 0);
    chk({tag, "_corner_count"}, corner_count, 0);
  endtask

  // Runs one frame; exp_cycles < 0 skips the frame-time check.
  task automatic run_frame(input string tag, input int mx, input int my, input int t,
                           input int exp_cycles, input bit poke);
    int s, nc, interior, cyc, first_wr;
    nc = 0; interior = 0;
    for (int yy = 0; yy <= my; yy++)
      for (int xx = 0; xx <= mx; xx++) begin
        s = ref_score(xx, yy, mx, my, t);
        exp_q.push_back({XW'(xx), YW'(yy), SW'(s)});
        if (s != 0) nc++;
        if (!ref_border(xx, yy, mx, my)) interior++;
      end
    rd_cnt = 0;
    @(negedge clk);
    max_x = XW'(mx); max_y = YW'(my); threshold = PW'(t); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; first_wr = 0;
    chk({tag, "_busy_after_start"}, busy, 1);
    while (!done && cyc < 40000) begin
      if (bus.wr_en && first_wr == 0) first_wr = cyc;
      if (poke && cyc == 30) begin
        start = 1'b1; max_x = XW'(2); max_y = YW'(2); threshold = '0;
      end else start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout done=0 after %0d cycles state_dbg=%0d", tag, cyc, state_dbg);
    end
    if (exp_cycles < 0) exp_cycles = 21 * interior + 2 * ((mx + 1) * (my + 1) - interior) + 1;
    else exp_cycles = exp_cycles;
    if (ready_mode != 1) chk({tag, "_frame_cycles"}, cyc, exp_cycles);
    chk({tag, "_first_wr_cycle"}, first_wr, 2);
    chk({tag, "_done_busy"}, busy, 0);
    chk({tag, "_reads"}, rd_cnt, 17 * interior);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
`ifdef FAST_CORNER_COUNT_EN
    chk({tag, "_corner_count"}, corner_count, (nc > 65535) ? 65535 : nc);
`else
    chk({tag, "_corner_count"}, corner_count, 0);
`endif
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int mx, my, t, waited;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    n_rst = 1'b1;
    @(negedge clk);

    // Uniform 7x7: only (3,3) reads, all scores zero, 118 = 117 + start cycle.
    fill(100);
    run_frame("flat", 6, 6, 20, 118, 0);

    // Bright arc of 9 -> 270.
    fill(100); set_ring(1, 9, 150);
    run_frame("bright9", 6, 6, 20, -1, 0);

    // Arc of 8 is one short -> 0.
    fill(100); set_ring(1, 8, 150);
    run_frame("bright8", 6, 6, 20, -1, 0);

    // Dark arc wrapping 13..16,1..5 -> 270.
    fill(100); set_ring(13, 16, 50); set_ring(1, 5, 50);
    run_frame("dark_wrap", 6, 6, 20, -1, 0);

    // Saturation: 16*255 exceeds 2047.
    fill(255); mem[3][3] = 8'd0;
    run_frame("saturate", 6, 6, 0, -1, 0);

    // Stall the (3,3) write for 5 cycles: frame grows by 5.
    fill(100); set_ring(1, 9, 150);
    ready_mode = 2; stall_cnt = 0;
    run_frame("stall", 6, 6, 20, 123, 0);
    ready_mode = 0;

    // Randomised frames, including degenerate sizes, with random back-pressure.
    ready_mode = 1;
    for (int n = 0; n < 6; n++) begin
      random_image();
      mx = (n == 0) ? 1 : $urandom_range(0, 13);
      my = (n == 0) ? 2 : $urandom_range(0, 13);
      t  = $urandom_range(0, 40);
      run_frame("random", mx, my, t, -1, (n == 1) && ((mx + 1) * (my + 1) >= 20));
    end
    // Guaranteed start-while-busy frame.
    random_image();
    run_frame("poke", 12, 10, 25, -1, 1);
    ready_mode = 0;

    // Reset in the middle of the (3,3) fetch.
    fill(100); set_ring(1, 9, 150);
    for (int yy = 0; yy <= 6; yy++)
      for (int xx = 0; xx <= 6; xx++)
        exp_q.push_back({XW'(xx), YW'(yy), SW'(ref_score(xx, yy, 6, 6, 20))});
    rd_cnt = 0;
    @(negedge clk);
    max_x = XW'(6); max_y = YW'(6); threshold = PW'(20); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (rd_cnt < 8 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    chk("rst_reached_fetch", rd_cnt, 8);
    n_rst = 1'b0;
    #1;
    check_all_zero("midrst");
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    random_image();
    run_frame("after_rst", 5, 5, 10, 73, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
